part3: RTL and testbench

- Sequential 8-bit fixed-point square-root unit.
- Input x is an unsigned Q0.8 fraction; output y = floor(sqrt(x·256)), also Q0.8, so y/256 ≈ sqrt(x/256).
- Free-running: it continuously samples x, runs an 8-iteration digit-by-digit (restoring) root, then updates y.
- Sits as a standalone datapath stage with no handshake; downstream logic samples y after the stated latency.

---
 rtl/part3.sv | 76 +++++++
 tb/tb_part3.sv | 192 +++++++++++++++++++
 2 files changed

// File: rtl/part3.sv
// Free-running 8-bit Q0.8 square-root unit: restoring digit-by-digit root over a
// fixed 10-cycle frame (LOAD, 8 x ITER, WRITE), result held in a register.
module part3 #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] x,
  output logic [WIDTH-1:0] y
);

  typedef enum logic [1:0] {LOAD, ITER, WRITE} state_t;

  localparam logic [2:0] LAST = 3'(WIDTH - 1);

  state_t             state;
  logic [2*WIDTH-1:0] rad;
  logic [WIDTH+1:0]   rem;
  logic [WIDTH-1:0]   root;
  logic [2:0]         i;

  logic [WIDTH+1:0]   rem_shift;
  logic [WIDTH+1:0]   trial;
  logic [WIDTH+1:0]   rem_next;
  logic [WIDTH-1:0]   root_next;

  // rem never exceeds 2*root before a shift, so its top two bits are always zero
  // there and only the low WIDTH bits feed the next step.
  logic unused_rem_bits;
  assign unused_rem_bits = ^rem[WIDTH+1:WIDTH];

  always_comb begin
    rem_shift = {rem[WIDTH-1:0], rad[2*WIDTH-1 -: 2]};
    trial     = {root, 2'b01};
    rem_next  = rem_shift;
    root_next = {root[WIDTH-2:0], 1'b0};
    if (rem_shift >= trial) begin
      rem_next  = rem_shift - trial;
      root_next = {root[WIDTH-2:0], 1'b1};
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= LOAD;
      rad   <= '0;
      rem   <= '0;
      root  <= '0;
      i     <= '0;
      y     <= '0;
    end else begin
      case (state)
        LOAD: begin
          rad   <= {x, {WIDTH{1'b0}}};
          rem   <= '0;
          root  <= '0;
          i     <= '0;
          state <= ITER;
        end
        ITER: begin
          rad  <= {rad[2*WIDTH-3:0], 2'b00};
          rem  <= rem_next;
          root <= root_next;
          i    <= i + 3'd1;
          if (i == LAST) state <= WRITE;
        end
        WRITE: begin
          y     <= root;
          state <= LOAD;
        end
        default: state <= LOAD;
      endcase
    end
  end

endmodule

// File: tb/tb_part3.sv
// Directed self-checking bench for the part3 square-root unit.
module tb_part3;

  logic       clk;
  logic       rst_n;
  logic [7:0] x;
  logic [7:0] y;

  int vectors;
  int miscompares;

  part3 #(.WIDTH(8)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .x     (x),
    .y     (y)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached, vectors=%0d", vectors);
    $fatal(1, "[TB] watchdog expired");
  end

  function automatic int isqrt(input int v);
    int r;
    r = 0;
    while ((r + 1) * (r + 1) <= v) r++;
    return r;
  endfunction

  task automatic wait_edge();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    logic [7:0] exp;
    x     = 8'hAA;
    rst_n = 1'b0;
    #1;
    vectors++;
    if (y !== 8'h00) begin
      miscompares++;
      $display("FAIL reset_async: y=%h expected=%h", y, 8'h00);
    end
    for (int k = 0; k < 3; k++) begin
      wait_edge();
      vectors++;
      if (y !== 8'h00) begin
        miscompares++;
        $display("FAIL reset_hold[%0d]: y=%h expected=%h", k, y, 8'h00);
      end
    end
    @(negedge clk) rst_n = 1'b1;
    // First edge after release is the LOAD edge; y updates on the 10th.
    for (int k = 1; k <= 20; k++) begin
      wait_edge();
      exp = (k >= 10) ? 8'hD0 : 8'h00;
      vectors++;
      if (y !== exp) begin
        miscompares++;
        $display("FAIL reset_latency[%0d]: y=%h expected=%h", k, y, exp);
      end
    end
  endtask

  task automatic test_basic();
    x = 8'hCC;
    repeat (20) wait_edge();
    vectors++;
    if (y !== 8'hE4) begin
      miscompares++;
      $display("FAIL basic_cc: y=%h expected=%h", y, 8'hE4);
    end
  endtask

  task automatic test_boundaries();
    logic [7:0] xs [4];
    logic [7:0] ys [4];
    xs = '{8'h00, 8'hFF, 8'h01, 8'h40};
    ys = '{8'h00, 8'hFF, 8'h10, 8'h80};
    for (int n = 0; n < 4; n++) begin
      x = xs[n];
      repeat (20) wait_edge();
      vectors++;
      if (y !== ys[n]) begin
        miscompares++;
        $display("FAIL boundary x=%h: y=%h expected=%h", xs[n], y, ys[n]);
      end
    end
  endtask

  task automatic test_mid_frame();
    logic [7:0] exp;
    rst_n = 1'b0;
    x     = 8'hAA;
    wait_edge();
    @(negedge clk) rst_n = 1'b1;
    for (int k = 1; k <= 20; k++) begin
      wait_edge();
      if (k < 10)      exp = 8'h00;
      else if (k < 20) exp = 8'hD0;
      else             exp = 8'hE4;
      vectors++;
      if (y !== exp) begin
        miscompares++;
        $display("FAIL mid_frame[%0d]: y=%h expected=%h", k, y, exp);
      end
      if (k == 4) x = 8'hCC;
    end
  endtask

  task automatic test_async_reset();
    bit seen;
    repeat (3) wait_edge();
    #2;
    vectors++;
    if (y !== 8'hE4) begin
      miscompares++;
      $display("FAIL async_pre: y=%h expected=%h", y, 8'hE4);
    end
    rst_n = 1'b0;
    #1;
    vectors++;
    if (y !== 8'h00) begin
      miscompares++;
      $display("FAIL async_drop: y=%h expected=%h", y, 8'h00);
    end
    wait_edge();
    vectors++;
    if (y !== 8'h00) begin
      miscompares++;
      $display("FAIL async_hold: y=%h expected=%h", y, 8'h00);
    end
    @(negedge clk) rst_n = 1'b1;
    seen = 1'b0;
    for (int k = 0; k < 19 && !seen; k++) begin
      wait_edge();
      if (y === 8'hE4) seen = 1'b1;
    end
    vectors++;
    if (!seen) begin
      miscompares++;
      $display("FAIL async_recover: y=%h expected=%h within 19 cycles", y, 8'hE4);
    end
  endtask

  task automatic test_sweep();
    logic [7:0] exp;
    logic [7:0] prev;
    prev = 8'h00;
    for (int v = 0; v < 256; v++) begin
      x = 8'(v);
      repeat (20) wait_edge();
      exp = 8'(isqrt(v * 256));
      vectors++;
      if (y !== exp) begin
        miscompares++;
        $display("FAIL sweep x=%h: y=%h expected=%h", x, y, exp);
      end
      vectors++;
      if (y < prev) begin
        miscompares++;
        $display("FAIL monotonic x=%h: y=%h below previous=%h", x, y, prev);
      end
      prev = y;
    end
  endtask

  initial begin
    vectors     = 0;
    miscompares = 0;
    rst_n       = 1'b1;
    x           = 8'h00;
    $display("[TB] starting part3 checks");
    test_reset();
    test_basic();
    test_boundaries();
    test_mid_frame();
    test_async_reset();
    test_sweep();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
